draw_arbiter: RTL and testbench

DRAW_ARBITER -- requirements
Module: draw_arbiter

---
 rtl/draw_arbiter_pkg.sv | 31 +++
 rtl/draw_arb_pick.sv | 39 +++
 rtl/draw_arbiter.sv | 116 +++++++++++
 tb/tb_draw_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_arbiter_pkg.sv
// Shared types and constants for the draw arbiter: FSM states, requester indices
// and pixel field widths.
package draw_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int NUM_REQ    = 4;
    localparam int ID_W       = 2;

    localparam int REQ_PLAYER = 0;
    localparam int REQ_B0     = 1;
    localparam int REQ_B1     = 2;
    localparam int REQ_INIT   = 3;

    localparam int X_W        = 8;
    localparam int Y_W        = 7;
    localparam int COL_W      = 3;

    function automatic logic [ID_W-1:0] onehot_to_id(input logic [NUM_REQ-1:0] oh);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (oh[i]) id = ID_W'(i);
        return id;
    endfunction

endpackage

// File: rtl/draw_arb_pick.sv
// Winner selection for the draw arbiter. DRAW_ARB_RR_EN selects rotating priority
// from ptr; otherwise fixed priority init > player > boulder_0 > boulder_1.
module draw_arb_pick
    import draw_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
`ifdef DRAW_ARB_RR_EN
    input  logic [ID_W-1:0]    ptr,
`endif
    output logic [NUM_REQ-1:0] winner
);

`ifdef DRAW_ARB_RR_EN
    logic [ID_W-1:0] idx;

    // Walk from furthest to nearest so the requester closest to ptr wins last.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + ID_W'(k);
            if (req[idx]) winner = NUM_REQ'(1) << idx;
        end
    end
`else
    always_comb begin
        winner = '0;
        if (req[REQ_INIT])
            winner[REQ_INIT] = 1'b1;
        else if (req[REQ_PLAYER])
            winner[REQ_PLAYER] = 1'b1;
        else if (req[REQ_B0])
            winner[REQ_B0] = 1'b1;
        else if (req[REQ_B1])
            winner[REQ_B1] = 1'b1;
    end
`endif

endmodule

// File: rtl/draw_arbiter.sv
// Arbitrates four pixel-drawing clients onto one VGA write port in bursts, with
// forced release after MAX_BURST cycles. Round-robin under DRAW_ARB_RR_EN.
module draw_arbiter
    import draw_arbiter_pkg::*;
#(
    parameter int MAX_BURST  = 1024,
    parameter int GAP_CYCLES = 1
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       done,
    input  logic [NUM_REQ*X_W-1:0]   x_in,
    input  logic [NUM_REQ*Y_W-1:0]   y_in,
    input  logic [NUM_REQ*COL_W-1:0] colour_in,
    input  logic [NUM_REQ-1:0]       plot_in,
    output logic [NUM_REQ-1:0]       grant,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy,
    output logic [X_W-1:0]           vga_x,
    output logic [Y_W-1:0]           vga_y,
    output logic [COL_W-1:0]         vga_colour,
    output logic                     vga_plot,
    output logic                     timeout
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t             state;
    logic [CNT_W-1:0]   burst_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [NUM_REQ-1:0] winner;
    logic               at_max;
    logic               own_done;
    logic               own_req;

`ifdef DRAW_ARB_RR_EN
    logic [ID_W-1:0]    ptr;
`endif

    draw_arb_pick u_pick (
        .req    (req),
`ifdef DRAW_ARB_RR_EN
        .ptr    (ptr),
`endif
        .winner (winner)
    );

    assign at_max   = (burst_cnt == CNT_LAST);
    assign own_done = done[grant_id];
    assign own_req  = req[grant_id];

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            grant      <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            timeout    <= 1'b0;
            burst_cnt  <= '0;
            gap_cnt    <= '0;
`ifdef DRAW_ARB_RR_EN
            ptr        <= '0;
`endif
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    vga_plot <= 1'b0;
                    if (|req) begin
                        grant     <= winner;
                        grant_id  <= onehot_to_id(winner);
                        busy      <= 1'b1;
                        burst_cnt <= '0;
                        state     <= BURST;
`ifdef DRAW_ARB_RR_EN
                        ptr       <= onehot_to_id(winner) + 1'b1;
`endif
                    end
                end
                BURST: begin
                    // The exit cycle still forwards the grantee's pixel.
                    vga_x      <= x_in[grant_id*X_W +: X_W];
                    vga_y      <= y_in[grant_id*Y_W +: Y_W];
                    vga_colour <= colour_in[grant_id*COL_W +: COL_W];
                    vga_plot   <= plot_in[grant_id];
                    if (own_done || !own_req || at_max) begin
                        timeout <= at_max && !own_done && own_req;
                        grant   <= '0;
                        busy    <= 1'b0;
                        gap_cnt <= '0;
                        state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else if (burst_cnt != '1) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                GAP: begin
                    vga_plot <= 1'b0;
                    if (gap_cnt == GAP_LAST)
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_arbiter.sv
// Bench for draw_arbiter: directed scenarios followed by random traffic, all
// checked against a transaction-level reference of owner / gap / pixel rules.
module tb_draw_arbiter;

    localparam int MAXB = 8;
    localparam int GAPC = 1;

    logic        clock = 1'b0;
    logic        resetn;
    logic [3:0]  req, done, plot_in;
    logic [31:0] x_in;
    logic [27:0] y_in;
    logic [11:0] colour_in;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic        busy, vga_plot, timeout;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: current owner (-1 none), cycles held, gap cycles left.
    int         m_own  = -1;
    int         m_held = 0;
    int         m_gap  = 0;
    int         m_ptr  = 0;
    int         m_gid  = 0;
    logic [7:0] m_x    = '0;
    logic [6:0] m_y    = '0;
    logic [2:0] m_c    = '0;
    logic       m_plot = 1'b0;
    logic       m_to   = 1'b0;

    draw_arbiter #(.MAX_BURST(MAXB), .GAP_CYCLES(GAPC)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .req        (req),
        .done       (done),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .plot_in    (plot_in),
        .grant      (grant),
        .grant_id   (grant_id),
        .busy       (busy),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .timeout    (timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_pick(input logic [3:0] r);
`ifdef DRAW_ARB_RR_EN
        for (int k = 0; k < 4; k++)
            if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
`else
        int order [4] = '{3, 0, 1, 2};
        for (int k = 0; k < 4; k++)
            if (r[order[k]]) return order[k];
`endif
        return -1;
    endfunction

    task automatic model_tick();
        m_to = 1'b0;
        if (!resetn) begin
            m_own = -1; m_held = 0; m_gap = 0; m_ptr = 0; m_gid = 0;
            m_x = '0; m_y = '0; m_c = '0; m_plot = 1'b0;
        end else if (m_own >= 0) begin
            m_x    = 8'(x_in >> (8 * m_own));
            m_y    = 7'(y_in >> (7 * m_own));
            m_c    = 3'(colour_in >> (3 * m_own));
            m_plot = plot_in[m_own];
            if (done[m_own] || !req[m_own] || m_held == MAXB - 1) begin
                m_to  = (m_held == MAXB - 1) && !done[m_own] && req[m_own];
                m_own = -1;
                m_gap = GAPC;
            end else begin
                m_held++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
            m_plot = 1'b0;
        end else begin
            m_plot = 1'b0;
            if (req != 4'b0) begin
                m_own  = ref_pick(req);
                m_gid  = m_own;
                m_held = 0;
                m_ptr  = (m_own + 1) % 4;
            end
        end
    endtask

    task automatic check_all();
        check("grant", 32'(grant), (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
        check("busy", 32'(busy), 32'(m_own >= 0));
        if (m_own >= 0) check("grant_id", 32'(grant_id), 32'(m_gid));
        check("vga_plot", 32'(vga_plot), 32'(m_plot));
        check("vga_x", 32'(vga_x), 32'(m_x));
        check("vga_y", 32'(vga_y), 32'(m_y));
        check("vga_colour", 32'(vga_colour), 32'(m_c));
        check("timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic step();
        @(posedge clock);
        model_tick();
        #1;
        check_all();
    endtask

    task automatic wait_busy(input int max, input string tag);
        int n = 0;
        while (!busy && n < max) begin
            step();
            n++;
        end
        check(tag, 32'(busy), 32'd1);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_g;
        int nb, nto, guard;
        logic [7:0] xs;

        resetn = 1'b0; req = '0; done = '0; plot_in = '0;
        x_in = '0; y_in = '0; colour_in = '0;
        step();
        step();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        resetn = 1'b1;

        // Single player burst with five plotted pixels, then done.
        req = 4'b0001;
        step();
        check("r33_grant", 32'(grant), 32'h1);
        plot_in = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            xs = 8'($urandom);
            x_in = {24'($urandom), xs};
            step();
            check("r33_plot", 32'(vga_plot), 32'd1);
            check("r33_x", 32'(vga_x), 32'(xs));
        end
        plot_in = 4'b0000;
        done = 4'b0001;
        step();
        check("r33_release", 32'(grant), 32'd0);
        done = 4'b0000;
        step();
        check("r33_gap", 32'(busy), 32'd0);
        step();
        check("r33_idle_grant", 32'(grant), 32'h1);
        req = 4'b0000;
        done = 4'b0001;
        step();
        done = 4'b0000;

        // Four back-to-back bursts with every requester asking.
        do_reset();
        req = 4'b1111;
        for (int b = 0; b < 4; b++) begin
            wait_busy(6, "r34_busy");
`ifdef DRAW_ARB_RR_EN
            exp_g = 4'b0001 << b;
`else
            exp_g = 4'b1000;
`endif
            check("r34_grant", 32'(grant), 32'(exp_g));
            done = grant;
            step();
            done = 4'b0000;
        end
        req = 4'b0000;

        // Held request with no done is force-released after MAXB cycles.
        do_reset();
        req = 4'b0010;
        wait_busy(3, "r35_busy");
        check("r35_grant", 32'(grant), 32'h2);
        nb = 1; nto = 0; guard = 0;
        while (busy && guard < 20) begin
            step();
            guard++;
            if (busy) nb++;
            if (timeout) nto++;
        end
        step();
        if (timeout) nto++;
        check("r35_cycles", 32'(nb), 32'(MAXB));
        check("r35_timeouts", 32'(nto), 32'd1);
        wait_busy(3, "r35_regrant_busy");
        check("r35_regrant", 32'(grant), 32'h2);
        req = 4'b0000;

        // Non-grantee plot and x are ignored.
        do_reset();
        req = 4'b0001;
        wait_busy(3, "r36_busy");
        plot_in = 4'b0100;
        x_in = 32'h00AA_0011;
        step();
        check("r36_plot", 32'(vga_plot), 32'd0);
        check("r36_x", 32'(vga_x), 32'h11);

        // Reset in the middle of a burst.
        plot_in = 4'b0001;
        step();
        check("r37_plot_before", 32'(vga_plot), 32'd1);
        resetn = 1'b0;
        step();
        check("r37_grant", 32'(grant), 32'd0);
        check("r37_plot", 32'(vga_plot), 32'd0);
        check("r37_busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        plot_in = 4'b0000;
        req = 4'b0100;
        wait_busy(2, "r37_regrant_busy");
        check("r37_regrant", 32'(grant), 32'h4);

        // Random traffic with occasional resets.
        do_reset();
        req = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(7) == 0) req[i] = ~req[i];
            done      = ($urandom_range(15) == 0) ? 4'($urandom) : 4'b0000;
            plot_in   = 4'($urandom);
            x_in      = $urandom;
            y_in      = 28'($urandom);
            colour_in = 12'($urandom);
            resetn    = ($urandom_range(499) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
